// File: rtl/wb_defs.sv
// Shared Wishbone slave definitions: bus widths, FSM encoding and wait-counter width.
package wb_defs;
    localparam int WB_AW      = 8;
    localparam int WB_DW      = 8;
    localparam int WAIT_CNT_W = 3;
    localparam int REG_IDX_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } wb_state_t;
endpackage

// File: rtl/wb_slave_regfile.sv
// Control register array: single write port, indexed read mux, flat image for power-control logic.
module wb_slave_regfile
    import wb_defs::*;
#(
    parameter int               NUM_REGS = 4,
    parameter logic [WB_DW-1:0] RST_VAL  = 8'h00
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_wr_en,
    input  logic [REG_IDX_W-1:0]      i_wr_idx,
    input  logic [WB_DW-1:0]          i_wr_dat,
    input  logic [REG_IDX_W-1:0]      i_rd_idx,
    output logic [WB_DW-1:0]          o_rd_dat,
    output logic [WB_DW*NUM_REGS-1:0] o_regs,
    output logic                      o_wr_pulse,
    output logic [REG_IDX_W-1:0]      o_wr_idx
);

    logic [WB_DW-1:0]     r_regs [NUM_REGS];
    logic                 r_wr_pulse;
    logic [REG_IDX_W-1:0] r_wr_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                r_regs[k] <= RST_VAL;
            end
            r_wr_pulse <= 1'b0;
            r_wr_idx   <= '0;
        end else begin
            r_wr_pulse <= i_wr_en;
            if (i_wr_en) begin
                r_wr_idx <= i_wr_idx;
                for (int k = 0; k < NUM_REGS; k++) begin
                    if (i_wr_idx == REG_IDX_W'(k)) begin
                        r_regs[k] <= i_wr_dat;
                    end
                end
            end
        end
    end

    // Loop compare keeps an out-of-range index from selecting a nonexistent entry.
    always_comb begin
        o_rd_dat = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (i_rd_idx == REG_IDX_W'(k)) begin
                o_rd_dat = r_regs[k];
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_pack
        assign o_regs[WB_DW*g +: WB_DW] = r_regs[g];
    end

    assign o_wr_pulse = r_wr_pulse;
    assign o_wr_idx   = r_wr_idx;

endmodule

// File: rtl/wb_slave_regs.sv
// Wishbone classic slave: NUM_REGS R/W registers plus a status byte, WAIT_STATES-delayed ack.
// Define WB_SLAVE_ERR_EN to terminate address misses with wb_err_o instead of wb_ack_o.
module wb_slave_regs
    import wb_defs::*;
#(
    parameter logic [WB_AW-1:0] BASE_ADDR   = 8'h40,
    parameter int               NUM_REGS    = 4,
    parameter int               WAIT_STATES = 0,
    parameter logic [WB_DW-1:0] RST_VAL     = 8'h00
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wb_cyc_i,
    input  logic                      wb_stb_i,
    input  logic                      wb_we_i,
    input  logic                      wb_sel_i,
    input  logic [WB_AW-1:0]          wb_adr_i,
    input  logic [WB_DW-1:0]          wb_dat_i,
    output logic [WB_DW-1:0]          wb_dat_o,
    output logic                      wb_ack_o,
    output logic                      wb_err_o,
    input  logic [WB_DW-1:0]          status_i,
    output logic [WB_DW*NUM_REGS-1:0] regs_o,
    output logic                      wr_pulse_o,
    output logic [REG_IDX_W-1:0]      wr_idx_o,
    output wb_state_t                 dbg_state_o
);

`ifdef WB_SLAVE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST =
        WAIT_CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
    // One extra bit so the window end never wraps past 8'hFF.
    localparam logic [WB_AW:0] REG_END = {1'b0, BASE_ADDR} + (WB_AW + 1)'(NUM_REGS);

    wb_state_t             r_state;
    wb_state_t             w_next;
    logic [WAIT_CNT_W-1:0] r_wait_cnt;
    logic [WB_AW-1:0]      r_adr;
    logic [WB_DW-1:0]      r_dat;
    logic                  r_we;
    logic                  r_sel;
    logic [WB_DW-1:0]      r_rdat;

    logic                  w_req;
    logic [WB_AW-1:0]      w_adr;
    logic [WB_DW-1:0]      w_dat;
    logic                  w_we;
    logic                  w_sel;
    logic                  w_hit_reg;
    logic                  w_hit_stat;
    logic                  w_miss;
    logic                  w_enter_resp;
    logic                  w_wr_en;
    logic [REG_IDX_W-1:0]  w_reg_idx;
    logic [WB_DW-1:0]      w_reg_rdat;
    logic                  w_ack;
    logic                  w_err;

    assign w_req = wb_cyc_i & wb_stb_i;

    // In IDLE the live bus is the request being accepted; afterwards only the latched copy counts.
    assign w_adr = (r_state == ST_IDLE) ? wb_adr_i : r_adr;
    assign w_dat = (r_state == ST_IDLE) ? wb_dat_i : r_dat;
    assign w_we  = (r_state == ST_IDLE) ? wb_we_i  : r_we;
    assign w_sel = (r_state == ST_IDLE) ? wb_sel_i : r_sel;

    assign w_hit_reg    = (w_adr >= BASE_ADDR) && ({1'b0, w_adr} < REG_END);
    assign w_hit_stat   = ({1'b0, w_adr} == REG_END);
    assign w_miss       = !w_hit_reg && !w_hit_stat;
    assign w_reg_idx    = REG_IDX_W'(w_adr - BASE_ADDR);
    assign w_enter_resp = (w_next == ST_RESP);
    assign w_wr_en      = w_enter_resp && w_we && w_sel && w_hit_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_next = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                if (!wb_cyc_i) begin
                    w_next = ST_IDLE;
                end else if (r_wait_cnt == WAIT_LAST) begin
                    w_next = ST_RESP;
                end
            end
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_ack = 1'b0;
        w_err = 1'b0;
        if (r_state == ST_RESP) begin
            w_err = ERR_EN && w_miss;
            w_ack = !w_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if (r_state == ST_WAIT && w_next == ST_WAIT) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end else begin
            r_wait_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_adr  <= '0;
            r_dat  <= '0;
            r_we   <= 1'b0;
            r_sel  <= 1'b0;
            r_rdat <= '0;
        end else begin
            if (r_state == ST_IDLE && w_req) begin
                r_adr <= wb_adr_i;
                r_dat <= wb_dat_i;
                r_we  <= wb_we_i;
                r_sel <= wb_sel_i;
            end
            if (w_enter_resp) begin
                if (w_we)            r_rdat <= '0;
                else if (w_hit_reg)  r_rdat <= w_reg_rdat;
                else if (w_hit_stat) r_rdat <= status_i;
                else                 r_rdat <= '0;
            end
        end
    end

    wb_slave_regfile #(
        .NUM_REGS (NUM_REGS),
        .RST_VAL  (RST_VAL)
    ) u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_wr_en    (w_wr_en),
        .i_wr_idx   (w_reg_idx),
        .i_wr_dat   (w_dat),
        .i_rd_idx   (w_reg_idx),
        .o_rd_dat   (w_reg_rdat),
        .o_regs     (regs_o),
        .o_wr_pulse (wr_pulse_o),
        .o_wr_idx   (wr_idx_o)
    );

    assign wb_ack_o    = w_ack;
    assign wb_err_o    = w_err;
    assign wb_dat_o    = w_ack ? r_rdat : '0;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_wb_slave_regs.sv
// Randomized bench for wb_slave_regs: two instances (0 and 3 wait states) against an array model.
module tb_wb_slave_regs;
    import wb_defs::*;

    localparam logic [7:0] BASE = 8'h40;
    localparam int         NREG = 4;
`ifdef WB_SLAVE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] status;

    logic        cyc [2];
    logic        stb [2];
    logic        we  [2];
    logic        sel [2];
    logic [7:0]  adr [2];
    logic [7:0]  dat [2];
    logic [7:0]  rdat [2];
    logic        ack [2];
    logic        err [2];
    logic        wrp [2];
    logic [3:0]  widx [2];
    logic [31:0] regs [2];
    wb_state_t   st [2];

    int ws [2] = '{0, 3};

    logic [7:0] m_regs [2][NREG];
    logic [3:0] m_idx  [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_slave_regs #(.BASE_ADDR(BASE), .NUM_REGS(NREG), .WAIT_STATES(0), .RST_VAL(8'h00)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]), .wb_we_i(we[0]),
        .wb_sel_i(sel[0]), .wb_adr_i(adr[0]), .wb_dat_i(dat[0]), .wb_dat_o(rdat[0]),
        .wb_ack_o(ack[0]), .wb_err_o(err[0]), .status_i(status), .regs_o(regs[0]),
        .wr_pulse_o(wrp[0]), .wr_idx_o(widx[0]), .dbg_state_o(st[0])
    );

    wb_slave_regs #(.BASE_ADDR(BASE), .NUM_REGS(NREG), .WAIT_STATES(3), .RST_VAL(8'h00)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]), .wb_we_i(we[1]),
        .wb_sel_i(sel[1]), .wb_adr_i(adr[1]), .wb_dat_i(dat[1]), .wb_dat_o(rdat[1]),
        .wb_ack_o(ack[1]), .wb_err_o(err[1]), .status_i(status), .regs_o(regs[1]),
        .wr_pulse_o(wrp[1]), .wr_idx_o(widx[1]), .dbg_state_o(st[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_image(input int d);
        logic [31:0] img;
        img = '0;
        for (int k = 0; k < NREG; k++) img[8*k +: 8] = m_regs[d][k];
        return img;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < NREG; k++) m_regs[d][k] = 8'h00;
            m_idx[d] = 4'd0;
        end
    endtask

    task automatic bus_idle(input int d);
        cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0; sel[d] = 1'b0;
        adr[d] = 8'h00; dat[d] = 8'h00;
    endtask

    // One full classic cycle on instance d, driven from a negedge, checked against the model.
    task automatic do_txn(input int d, input logic t_we, input logic [7:0] t_adr,
                          input logic [7:0] t_dat, input logic t_sel);
        int  n;
        bit  done;
        bit  hit_reg, hit_stat, miss, commit, exp_err;
        logic [7:0] exp_rd;
        hit_reg  = (t_adr >= BASE) && (int'(t_adr) < int'(BASE) + NREG);
        hit_stat = (int'(t_adr) == int'(BASE) + NREG);
        miss     = !hit_reg && !hit_stat;
        exp_err  = ERR_EN && miss;
        commit   = t_we && t_sel && hit_reg;
        if (t_we || miss) exp_rd = 8'h00;
        else if (hit_reg) exp_rd = m_regs[d][t_adr - BASE];
        else              exp_rd = status;

        cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = t_we; sel[d] = t_sel;
        adr[d] = t_adr; dat[d] = t_dat;
        n = 0;
        done = 0;
        while (!done && n < 20) begin
            @(posedge clk); n++;
            @(negedge clk);
            if (ack[d] || err[d]) done = 1;
            else begin
                check("dat_idle", 32'(rdat[d]), 32'h0);
                check("wrp_early", 32'(wrp[d]), 32'h0);
                we[d]  = 1'($urandom_range(0, 1));
                sel[d] = 1'($urandom_range(0, 1));
                adr[d] = 8'($urandom_range(0, 255));
                dat[d] = 8'($urandom_range(0, 255));
            end
        end
        check("term_seen", 32'(done), 32'h1);
        check("latency", 32'(n), 32'(ws[d] + 1));
        check("ack", 32'(ack[d]), 32'(!exp_err));
        check("err", 32'(err[d]), 32'(exp_err));
        check("rdata", 32'(rdat[d]), 32'(exp_rd));
        check("wr_pulse", 32'(wrp[d]), 32'(commit));
        if (commit) begin
            m_regs[d][t_adr - BASE] = t_dat;
            m_idx[d] = 4'(t_adr - BASE);
        end
        check("regs", regs[d], model_image(d));
        check("wr_idx", 32'(widx[d]), 32'(m_idx[d]));
        bus_idle(d);
        @(posedge clk);
        @(negedge clk);
        check("ack_1cyc", 32'(ack[d] | err[d]), 32'h0);
        check("wrp_1cyc", 32'(wrp[d]), 32'h0);
        check("idle_after", 32'(st[d]), 32'(ST_IDLE));
    endtask

    initial begin
        bit seen;
        rst_n = 1'b0;
        status = 8'h00;
        bus_idle(0);
        bus_idle(1);
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_ack", 32'(ack[d] | err[d]), 32'h0);
            check("rst_dat", 32'(rdat[d]), 32'h0);
            check("rst_regs", regs[d], 32'h0);
            check("rst_widx", 32'(widx[d]), 32'h0);
            check("rst_state", 32'(st[d]), 32'(ST_IDLE));
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Directed scenarios on both latencies.
        for (int d = 0; d < 2; d++) begin
            do_txn(d, 1'b1, 8'h41, 8'hA5, 1'b1);
            do_txn(d, 1'b0, 8'h41, 8'h00, 1'b0);
            status = 8'h3C;
            do_txn(d, 1'b0, 8'h44, 8'h00, 1'b1);
            do_txn(d, 1'b1, 8'h44, 8'h77, 1'b1);
            do_txn(d, 1'b1, 8'h10, 8'h99, 1'b1);
            do_txn(d, 1'b0, 8'h10, 8'h00, 1'b1);
            do_txn(d, 1'b1, 8'h43, 8'h5E, 1'b0);
            do_txn(d, 1'b1, 8'h40, 8'hC3, 1'b1);
            do_txn(d, 1'b1, 8'h3F, 8'h11, 1'b1);
            do_txn(d, 1'b0, 8'h45, 8'h00, 1'b1);
        end

        // Abort: cyc dropped after one wait cycle.
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; sel[1] = 1'b1;
        adr[1] = 8'h42; dat[1] = 8'h5A;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        bus_idle(1);
        seen = 0;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            if (ack[1] || err[1] || wrp[1]) seen = 1;
        end
        check("abort_no_term", 32'(seen), 32'h0);
        check("abort_state", 32'(st[1]), 32'(ST_IDLE));
        check("abort_regs", regs[1], model_image(1));

        // Reset asserted while instance 1 waits.
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; sel[1] = 1'b1;
        adr[1] = 8'h41; dat[1] = 8'hEE;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("midrst_ack", 32'(ack[1] | err[1]), 32'h0);
        check("midrst_regs", regs[1], 32'h0);
        check("midrst_state", 32'(st[1]), 32'(ST_IDLE));
        check("midrst_regs0", regs[0], 32'h0);
        bus_idle(1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_txn(1, 1'b1, 8'h41, 8'h3D, 1'b1);
        do_txn(1, 1'b0, 8'h41, 8'h00, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            int d;
            logic [7:0] a;
            d = int'($urandom_range(0, 1));
            status = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 9) < 8) a = 8'($urandom_range(8'h3E, 8'h46));
            else                          a = 8'($urandom_range(0, 255));
            do_txn(d, 1'($urandom_range(0, 1)), a, 8'($urandom_range(0, 255)),
                   ($urandom_range(0, 7) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
